// File: rtl/test_sch_pkg.sv
// Shared constants and helpers for the ARINC-429 style link test block.
`timescale 1ns/1ps
package test_sch_pkg;

  localparam int WORD_LEN = 32;
  localparam int GAP_LEN  = 4;

  // Half-bit tick index of the last data half-bit and of the final gap half-bit.
  localparam logic [6:0] DAT_HALF  = 7'(2 * WORD_LEN);
  localparam logic [6:0] LAST_HALF = 7'(2 * (WORD_LEN + GAP_LEN));

  // Clocks per half-bit at 50 MHz for 12.5 / 50 / 100 / 200 kbit/s.
  function automatic logic [11:0] halfDiv(input logic [1:0] nvel);
    logic [11:0] div;
    case (nvel)
      2'd0:    div = 12'd2000;
      2'd1:    div = 12'd500;
      2'd2:    div = 12'd250;
      default: div = 12'd125;
    endcase
    return div;
  endfunction

  // Mirror a 23-bit field so the data LSB ends up adjacent to the label.
  function automatic logic [22:0] rev23(input logic [22:0] v);
    logic [22:0] r;
    for (int i = 0; i < 23; i++) r[22 - i] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/test_sch_arinc_rx.sv
// Loop-back receiver: detects line pulses, shifts in 32 bits, checks odd parity.
`timescale 1ns/1ps
module test_sch_arinc_rx
  import test_sch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_txd1,
  input  logic        i_txd0,
  input  logic [1:0]  i_nvel,
  output logic [7:0]  o_adr,
  output logic [22:0] o_dat,
  output logic        o_ok
);

  logic        r_d1Prev;
  logic        r_d0Prev;
  logic [31:0] r_sr;
  logic [5:0]  r_cnt;
  logic [13:0] r_nullCnt;

  logic        w_rise;
  logic [31:0] w_full;
  logic        w_timeout;

  assign w_rise    = (i_txd1 & ~r_d1Prev) | (i_txd0 & ~r_d0Prev);
  assign w_full    = {r_sr[30:0], i_txd1};
  assign w_timeout = r_nullCnt > {halfDiv(i_nvel), 2'b00};

  // Shift in one bit per line pulse; reload outputs on the 32nd, drop count on long null.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d1Prev  <= 1'b0;
      r_d0Prev  <= 1'b0;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_nullCnt <= '0;
      o_adr     <= '0;
      o_dat     <= '0;
      o_ok      <= 1'b0;
    end else begin
      r_d1Prev <= i_txd1;
      r_d0Prev <= i_txd0;
      if (i_txd1 | i_txd0)
        r_nullCnt <= '0;
      else if (!w_timeout)
        r_nullCnt <= r_nullCnt + 14'd1;
      if (w_rise) begin
        r_sr <= w_full;
        if (r_cnt == 6'd0)
          o_ok <= 1'b0;
        if (r_cnt == 6'(WORD_LEN - 1)) begin
          o_adr <= w_full[31:24];
          o_dat <= rev23(w_full[23:1]);
          o_ok  <= ^w_full;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end else if (w_timeout) begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/test_sch.sv
// ARINC-429 style transmitter with bipolar RZ output and loop-back receiver.
`timescale 1ns/1ps
module test_sch
  import test_sch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Nvel,
  input  logic [7:0]  ADR,
  input  logic [22:0] DAT,
  input  logic        st,
  output logic        ce_tx,
  output logic        TXD1,
  output logic        TXD0,
  output logic        SLP,
  output logic        en_tx_dat,
  output logic        en_tx_word,
  output logic        T_cp_tx,
  output logic        FT_tx,
  output logic        SDAT,
  output logic        QM,
  output logic [5:0]  cb_bit,
  output logic [7:0]  sr_adr_rx,
  output logic [22:0] sr_dat_rx,
  output logic        ok_rx
);

  logic        r_stPrev;
  logic [11:0] r_divCnt;
  logic [1:0]  r_nvel;
  logic        r_slp;
  logic [31:0] r_word;
  logic [6:0]  r_halfCnt;
  logic        r_enWord;
  logic        r_ft;
  logic        r_qm;

  logic [1:0]  w_nvelSel;
  logic [11:0] w_div;
  logic        w_ce;
  logic        w_start;
  logic [5:0]  w_cb;
  logic [4:0]  w_bitIdx;
  logic        w_enDat;
  logic        w_tcp;
  logic        w_sdat;

  // The rate is frozen for the duration of a word; the idle divider follows the input.
  assign w_nvelSel = r_enWord ? r_nvel : Nvel;
  assign w_div     = halfDiv(w_nvelSel);
  assign w_ce      = r_divCnt >= (w_div - 12'd1);
  assign w_start   = st & ~r_stPrev & ~r_enWord & ~r_ft;

  // r_halfCnt counts half-bit ticks since start: odd values are first halves.
  assign w_cb      = (r_halfCnt == 7'd0) ? 6'd0 : 6'((r_halfCnt - 7'd1) >> 1);
  assign w_bitIdx  = 5'd31 - w_cb[4:0];
  assign w_enDat   = r_enWord && (r_halfCnt <= DAT_HALF);
  assign w_tcp     = w_enDat && r_halfCnt[0];
  assign w_sdat    = (w_enDat && (r_halfCnt != 7'd0)) ? r_word[w_bitIdx] : 1'b0;

  assign ce_tx      = w_ce;
  assign TXD1       = w_tcp & w_sdat;
  assign TXD0       = w_tcp & ~w_sdat;
  assign SLP        = r_slp;
  assign en_tx_dat  = w_enDat;
  assign en_tx_word = r_enWord;
  assign T_cp_tx    = w_tcp;
  assign FT_tx      = r_ft;
  assign SDAT       = w_sdat;
  assign QM         = r_qm;
  assign cb_bit     = w_cb;

  // Free-running half-bit divider; wraps early if the rate shrinks under it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_divCnt <= '0;
    else if (w_ce)
      r_divCnt <= '0;
    else
      r_divCnt <= r_divCnt + 12'd1;
  end

  // Word sequencer: latch on start, step one half-bit per tick, pulse FT_tx at the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stPrev  <= 1'b0;
      r_nvel    <= '0;
      r_slp     <= 1'b0;
      r_word    <= '0;
      r_halfCnt <= '0;
      r_enWord  <= 1'b0;
      r_ft      <= 1'b0;
      r_qm      <= 1'b0;
    end else begin
      r_stPrev <= st;
      r_ft     <= 1'b0;
      if (w_start) begin
        r_enWord  <= 1'b1;
        r_halfCnt <= '0;
        r_qm      <= 1'b0;
        r_nvel    <= Nvel;
        r_slp     <= (Nvel == 2'd0);
        r_word    <= {ADR, rev23(DAT), ~^{ADR, DAT}};
      end else if (r_enWord && w_ce) begin
        if (r_halfCnt == LAST_HALF) begin
          r_enWord  <= 1'b0;
          r_halfCnt <= '0;
          r_ft      <= 1'b1;
        end else begin
          r_halfCnt <= r_halfCnt + 7'd1;
        end
        if (!r_halfCnt[0] && (r_halfCnt != 7'd0) && (r_halfCnt <= DAT_HALF))
          r_qm <= r_qm ^ w_sdat;
      end
    end
  end

  test_sch_arinc_rx u_arinc_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_txd1 (TXD1),
    .i_txd0 (TXD0),
    .i_nvel (w_nvelSel),
    .o_adr  (sr_adr_rx),
    .o_dat  (sr_dat_rx),
    .o_ok   (ok_rx)
  );

endmodule

// File: tb/tb_test_sch.sv
// Directed bench for test_sch: line decoding, timing, parity and loop-back receive.
`timescale 1ns/1ps
module tb_test_sch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  Nvel;
  logic [7:0]  ADR;
  logic [22:0] DAT;
  logic        st;
  logic        ce_tx, TXD1, TXD0, SLP, en_tx_dat, en_tx_word, T_cp_tx, FT_tx, SDAT, QM;
  logic [5:0]  cb_bit;
  logic [7:0]  sr_adr_rx;
  logic [22:0] sr_dat_rx;
  logic        ok_rx;

  typedef struct packed {
    logic [7:0]  adr;
    logic [22:0] dat;
    logic        par;
  } expWord_t;

  expWord_t sb[$];

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  // Observations gathered while a word is on the line.
  int          cyc, edgeCnt, rxCheckAt, okClearAt;
  int          violations, cbBad, cbMax, datLen, ceLast, ceBad, ceIntervals, firstEdgeCb, prevCb;
  bit          ftSeen;
  logic        firstBit, prevD1, prevD0;
  logic [31:0] txWord;

  test_sch dut (
    .clk(clk), .rst_n(rst_n), .Nvel(Nvel), .ADR(ADR), .DAT(DAT), .st(st),
    .ce_tx(ce_tx), .TXD1(TXD1), .TXD0(TXD0), .SLP(SLP), .en_tx_dat(en_tx_dat),
    .en_tx_word(en_tx_word), .T_cp_tx(T_cp_tx), .FT_tx(FT_tx), .SDAT(SDAT), .QM(QM),
    .cb_bit(cb_bit), .sr_adr_rx(sr_adr_rx), .sr_dat_rx(sr_dat_rx), .ok_rx(ok_rx)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] nv, input logic [7:0] adr, input logic [22:0] dat);
    expWord_t e;
    @(negedge clk);
    Nvel = nv; ADR = adr; DAT = dat; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    e.adr = adr; e.dat = dat; e.par = ~^{adr, dat};
    sb.push_back(e);
  endtask

  task automatic compareRx();
    expWord_t    e;
    logic [31:0] expW;
    if (sb.size() == 0) begin
      checkOutput("sbHasEntry", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      expW[31:24] = e.adr;
      for (int i = 0; i < 23; i++) expW[23 - i] = e.dat[i];
      expW[0] = e.par;
      checkOutput("txWord", txWord, expW);
      checkOutput("rxAdr", sr_adr_rx, e.adr);
      checkOutput("rxDat", sr_dat_rx, e.dat);
      checkOutput("rxOk", ok_rx, 1);
    end
  endtask

  task automatic waitWord(input int budget, input int divExp, input int injectAt,
                          input logic [7:0] injAdr, input logic [22:0] injDat, input int stopCb);
    cyc = 0; edgeCnt = 0; rxCheckAt = -1; okClearAt = -1;
    violations = 0; cbBad = 0; cbMax = 0; datLen = 0; ceLast = -1; ceBad = 0;
    ceIntervals = 0; firstEdgeCb = -1; ftSeen = 0; firstBit = 1'bx; txWord = '0;
    prevD1 = TXD1; prevD0 = TXD0; prevCb = int'(cb_bit);
    while (!ftSeen && cyc < budget && !(stopCb >= 0 && int'(cb_bit) == stopCb)) begin
      @(negedge clk);
      cyc++;
      if (injectAt >= 0) begin
        if (cyc == injectAt) begin ADR = injAdr; DAT = injDat; st = 1'b1; end
        else if (cyc == injectAt + 1) st = 1'b0;
      end
      if (TXD1 & TXD0) violations++;
      if (!T_cp_tx && (TXD1 | TXD0)) violations++;
      if (en_tx_dat) datLen++;
      if (ce_tx) begin
        if (ceLast >= 0) begin
          ceIntervals++;
          if (cyc - ceLast != divExp) ceBad++;
        end
        ceLast = cyc;
      end
      if (int'(cb_bit) != prevCb) begin
        if (!(int'(cb_bit) == prevCb + 1 || (cb_bit == 6'd0 && FT_tx))) cbBad++;
        prevCb = int'(cb_bit);
        if (prevCb > cbMax) cbMax = prevCb;
      end
      if ((TXD1 && !prevD1) || (TXD0 && !prevD0)) begin
        if (edgeCnt == 0) begin
          firstEdgeCb = int'(cb_bit);
          firstBit = TXD1;
          okClearAt = cyc + 2;
        end
        if (edgeCnt < 32) txWord = {txWord[30:0], TXD1};
        edgeCnt++;
        if (edgeCnt == 32) rxCheckAt = cyc + 2;
      end
      prevD1 = TXD1; prevD0 = TXD0;
      if (cyc == okClearAt) checkOutput("okClrFirstBit", ok_rx, 0);
      if (cyc == rxCheckAt) compareRx();
      if (FT_tx) ftSeen = 1;
    end
  endtask

  task automatic checkWord(input string pfx, input int div, input logic expPar);
    bit lenOk;
    lenOk = (datLen >= 63 * div) && (datLen <= 65 * div);
    checkOutput({pfx, "FtSeen"}, ftSeen, 1);
    checkOutput({pfx, "Edges"}, edgeCnt, 32);
    checkOutput({pfx, "LineRules"}, violations, 0);
    checkOutput({pfx, "CbSeq"}, cbBad, 0);
    checkOutput({pfx, "CbMax"}, cbMax, 35);
    checkOutput({pfx, "DatLen"}, lenOk, 1);
    checkOutput({pfx, "CeSpacing"}, ceBad, 0);
    checkOutput({pfx, "ParityBit"}, txWord[0], expPar);
    checkOutput({pfx, "QmEnd"}, QM, 1);
    checkOutput({pfx, "WordOff"}, en_tx_word, 0);
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "TXD1"}, TXD1, 0);
    checkOutput({pfx, "TXD0"}, TXD0, 0);
    checkOutput({pfx, "SLP"}, SLP, 0);
    checkOutput({pfx, "enDat"}, en_tx_dat, 0);
    checkOutput({pfx, "enWord"}, en_tx_word, 0);
    checkOutput({pfx, "Tcp"}, T_cp_tx, 0);
    checkOutput({pfx, "FT"}, FT_tx, 0);
    checkOutput({pfx, "SDAT"}, SDAT, 0);
    checkOutput({pfx, "QM"}, QM, 0);
    checkOutput({pfx, "cbBit"}, cb_bit, 0);
    checkOutput({pfx, "rxAdr"}, sr_adr_rx, 0);
    checkOutput({pfx, "rxDat"}, sr_dat_rx, 0);
    checkOutput({pfx, "okRx"}, ok_rx, 0);
  endtask

  // Directed sequence: reset, 50k word with ignored restart, back-to-back word, rate and abort cases.
  initial begin
    bit multiCe;
    rst_n = 1'b0; Nvel = 2'd1; ADR = '0; DAT = '0; st = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset_");
    checkOutput("reset_ceTx", ce_tx, 0);
    rst_n = 1'b1;

    $display("[TB] word 1: Nvel=1 ADR=88 DAT=4C6600, stray start at 25 us");
    applyStimulus(2'd1, 8'h88, 23'h4C6600);
    waitWord(40000, 500, 1250, 8'h11, 23'h7FFFFF, -1);
    checkWord("w1_", 500, 1'b0);

    $display("[TB] word 2: same word right after FT_tx at Nvel=3");
    applyStimulus(2'd3, 8'h88, 23'h4C6600);
    waitWord(12000, 125, -1, 8'h00, 23'h0, -1);
    checkWord("w2_", 125, 1'b0);

    $display("[TB] low speed: Nvel=0 ADR=FF DAT=0");
    applyStimulus(2'd0, 8'hFF, 23'h0);
    checkOutput("n0_SLP", SLP, 1);
    waitWord(6500, 2000, -1, 8'h00, 23'h0, -1);
    multiCe = (ceIntervals >= 2);
    checkOutput("n0_CeCount", multiCe, 1);
    checkOutput("n0_CeSpacing", ceBad, 0);
    checkOutput("n0_FirstBit", firstBit, 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sb.delete();

    $display("[TB] high speed: Nvel=3 ADR=FF DAT=0");
    applyStimulus(2'd3, 8'hFF, 23'h0);
    checkOutput("n3_SLP", SLP, 0);
    waitWord(12000, 125, -1, 8'h00, 23'h0, -1);
    checkWord("n3_", 125, 1'b1);

    $display("[TB] reset abort at bit 10");
    applyStimulus(2'd3, 8'h5A, 23'h123456);
    waitWord(4000, 125, -1, 8'h00, 23'h0, 10);
    checkOutput("abort_ReachedBit10", cb_bit, 10);
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("abort_");
    rst_n = 1'b1;
    sb.delete();

    $display("[TB] clean restart after abort");
    applyStimulus(2'd3, 8'hB5, 23'h00ABCD);
    waitWord(600, 125, -1, 8'h00, 23'h0, -1);
    checkOutput("restart_FirstEdgeCb", firstEdgeCb, 0);
    checkOutput("restart_FirstBit", firstBit, 1);
    checkOutput("restart_LineRules", violations, 0);
    sb.delete();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
